// File: rtl/seq_alu_if.sv
// Start/busy/done request/response bundle between the seq_alu and its issuing control FSM.
// The master drives start/op/operands; the slave returns status, registered result and flags.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             div0;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi, carry, zero, neg, ovf, div0
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi, carry, zero, neg, ovf, div0
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: 1-cycle add/sub/shift/logic, WIDTH+1-cycle bit-serial MUL/DIV (DIV only with SEQ_ALU_DIV_EN).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  seq_alu_if.slave     bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             div0;
  } res_t;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  res_t             res_q;
`ifdef SEQ_ALU_DIV_EN
  logic             is_div_q;
`endif

  logic [3:0]       op_dec;
  logic             iter_op;
  res_t             one_res;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_dif;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   mul_sum;
  res_t             iter_res;

  function automatic res_t with_flags(input res_t r);
    res_t t;
    t      = r;
    t.zero = (r.lo == '0);
    t.neg  = r.lo[MSB];
    return t;
  endfunction

  // Unused and (when the divider is compiled out) op 9 codes fall back to ADD.
  always_comb begin
    op_dec = bus.op;
    if (bus.op > OP_DIV) op_dec = OP_ADD;
`ifndef SEQ_ALU_DIV_EN
    if (bus.op == OP_DIV) op_dec = OP_ADD;
`endif
  end

`ifdef SEQ_ALU_DIV_EN
  assign iter_op = ((op_dec == OP_MUL) || (op_dec == OP_DIV)) && (bus.b != '0);
`else
  assign iter_op = (op_dec == OP_MUL) && (bus.b != '0);
`endif

  always_comb begin
    add_sum = {1'b0, bus.a} + {1'b0, bus.b};
    sub_dif = {1'b0, bus.a} - {1'b0, bus.b};
    one_res = '0;
    case (op_dec)
      OP_SUB: begin
        one_res.lo    = sub_dif[WIDTH-1:0];
        one_res.carry = sub_dif[WIDTH];
        one_res.ovf   = (bus.a[MSB] != bus.b[MSB]) && (sub_dif[MSB] != bus.a[MSB]);
      end
      OP_SHR: begin
        one_res.lo    = {1'b0, bus.a[WIDTH-1:1]};
        one_res.carry = bus.a[0];
      end
      OP_SHL: begin
        one_res.lo    = {bus.a[WIDTH-2:0], 1'b0};
        one_res.carry = bus.a[MSB];
      end
      OP_AND: one_res.lo = bus.a & bus.b;
      OP_OR:  one_res.lo = bus.a | bus.b;
      OP_NOT: one_res.lo = ~bus.a;
      OP_XOR: one_res.lo = bus.a ^ bus.b;
      OP_MUL: one_res.lo = '0;  // only reached with b==0
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: begin             // only reached with b==0
        one_res.lo   = '1;
        one_res.hi   = bus.a;
        one_res.div0 = 1'b1;
      end
`endif
      default: begin
        one_res.lo    = add_sum[WIDTH-1:0];
        one_res.carry = add_sum[WIDTH];
        one_res.ovf   = (bus.a[MSB] == bus.b[MSB]) && (add_sum[MSB] != bus.a[MSB]);
      end
    endcase
  end

  // MUL: {acc_hi,acc_lo} holds partial product over the shifting multiplier.
  // DIV: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0] div_sh;
  logic [WIDTH:0] div_dif;
  assign div_sh  = {acc_hi, acc_lo[MSB]};
  assign div_dif = div_sh - {1'b0, b_q};

  always_comb begin
    if (is_div_q) begin
      if (!div_dif[WIDTH]) begin
        step_hi = div_dif[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end
`else
  assign step_hi = mul_sum[WIDTH:1];
  assign step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif

  always_comb begin
    iter_res       = '0;
    iter_res.lo    = step_lo;
    iter_res.hi    = step_hi;
    iter_res.carry = (step_hi != '0);
`ifdef SEQ_ALU_DIV_EN
    if (is_div_q) iter_res.carry = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      b_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      res_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_ITER: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
            res_q <= with_flags(iter_res);
          end
        end
        default: begin  // IDLE and DONE both accept a new start
          if (bus.start) begin
            b_q      <= bus.b;
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= (op_dec == OP_DIV);
`endif
            if (iter_op) begin
              state  <= S_ITER;
              cnt    <= CNT_W'(WIDTH);
              acc_hi <= '0;
              acc_lo <= bus.a;
            end else begin
              state <= S_DONE;
              res_q <= with_flags(one_res);
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy      = (state == S_ITER);
  assign bus.done      = (state == S_DONE);
  assign bus.result    = res_q.lo;
  assign bus.result_hi = res_q.hi;
  assign bus.carry     = res_q.carry;
  assign bus.zero      = res_q.zero;
  assign bus.neg       = res_q.neg;
  assign bus.ovf       = res_q.ovf;
  assign bus.div0      = res_q.div0;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: each step drives one operation and asserts hand-computed results.
module tb_seq_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  seq_alu_if #(.WIDTH(16)) bus ();

  seq_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts clock edges from the start edge until done is seen; 0 means it never came.
  task automatic wait_done(input int already, output int cycles);
    cycles = already;
    while (!bus.done && cycles < 100) begin
      tick();
      cycles++;
    end
    if (!bus.done) cycles = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1 ({tag, "_busy"}, bus.busy, 1'b0);
    chk1 ({tag, "_done"}, bus.done, 1'b0);
    chk16({tag, "_result"}, bus.result, 16'h0000);
    chk16({tag, "_result_hi"}, bus.result_hi, 16'h0000);
    chk1 ({tag, "_flags"}, bus.carry | bus.zero | bus.neg | bus.ovf | bus.div0, 1'b0);
  endtask

  initial begin
    int lat;
    int pulses;
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;

    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // ADD wrap to zero
    issue(4'd0, 16'hFFFF, 16'h0001);
    wait_done(1, lat);
    chk_int("add_lat", lat, 1);
    chk16("add_res", bus.result, 16'h0000);
    chk1 ("add_carry", bus.carry, 1'b1);
    chk1 ("add_zero", bus.zero, 1'b1);
    chk1 ("add_ovf", bus.ovf, 1'b0);
    tick();
    chk1 ("add_done_pulse", bus.done, 1'b0);
    chk16("add_hold", bus.result, 16'h0000);

    // ADD signed overflow
    issue(4'd0, 16'h7FFF, 16'h0001);
    chk16("add2_res", bus.result, 16'h8000);
    chk1 ("add2_ovf", bus.ovf, 1'b1);
    chk1 ("add2_neg", bus.neg, 1'b1);
    chk1 ("add2_carry", bus.carry, 1'b0);

    // SUB cases
    issue(4'd1, 16'h8000, 16'h0001);
    chk1 ("sub1_done", bus.done, 1'b1);
    chk16("sub1_res", bus.result, 16'h7FFF);
    chk1 ("sub1_ovf", bus.ovf, 1'b1);
    chk1 ("sub1_carry", bus.carry, 1'b0);
    chk1 ("sub1_neg", bus.neg, 1'b0);
    issue(4'd1, 16'h0003, 16'h0005);
    chk16("sub2_res", bus.result, 16'hFFFE);
    chk1 ("sub2_carry", bus.carry, 1'b1);
    chk1 ("sub2_neg", bus.neg, 1'b1);
    chk1 ("sub2_ovf", bus.ovf, 1'b0);

    // Shifts and logic
    issue(4'd2, 16'h8001, 16'h0000);
    chk16("shr_res", bus.result, 16'h4000);
    chk1 ("shr_carry", bus.carry, 1'b1);
    issue(4'd3, 16'h8001, 16'h0000);
    chk16("shl_res", bus.result, 16'h0002);
    chk1 ("shl_carry", bus.carry, 1'b1);
    issue(4'd4, 16'hF0F0, 16'h3C3C);
    chk16("and_res", bus.result, 16'h3030);
    issue(4'd5, 16'hF0F0, 16'h0C0C);
    chk16("or_res", bus.result, 16'hFCFC);
    issue(4'd6, 16'h00FF, 16'h1234);
    chk16("not_res", bus.result, 16'hFF00);
    chk1 ("not_neg", bus.neg, 1'b1);
    chk1 ("not_carry", bus.carry, 1'b0);
    issue(4'd12, 16'h0010, 16'h0020);
    chk16("op12_as_add", bus.result, 16'h0030);
    tick();

    // MUL with an ignored mid-op start
    issue(4'd8, 16'h1234, 16'h0100);
    chk1("mul_busy", bus.busy, 1'b1);
    tick();
    bus.start = 1'b1;
    bus.op    = 4'd0;
    bus.a     = 16'h0001;
    bus.b     = 16'h0001;
    tick();
    bus.start = 1'b0;
    chk1("mul_busy_mid", bus.busy, 1'b1);
    wait_done(3, lat);
    chk_int("mul_lat", lat, 17);
    chk1 ("mul_busy_done", bus.busy, 1'b0);
    chk16("mul_lo", bus.result, 16'h3400);
    chk16("mul_hi", bus.result_hi, 16'h0012);
    chk1 ("mul_carry", bus.carry, 1'b1);
    tick();
    chk1 ("mul_ignored_start_done", bus.done, 1'b0);
    chk1 ("mul_ignored_start_busy", bus.busy, 1'b0);

    issue(4'd8, 16'hFFFF, 16'hFFFF);
    wait_done(1, lat);
    chk16("mulmax_lo", bus.result, 16'h0001);
    chk16("mulmax_hi", bus.result_hi, 16'hFFFE);
    issue(4'd8, 16'h1234, 16'h0000);
    chk_int("mul0_lat", bus.done ? 1 : 0, 1);
    chk16("mul0_res", bus.result, 16'h0000);
    chk1 ("mul0_zero", bus.zero, 1'b1);
    tick();

`ifdef SEQ_ALU_DIV_EN
    issue(4'd9, 16'd1000, 16'd7);
    wait_done(1, lat);
    chk_int("div_lat", lat, 17);
    chk16("div_quo", bus.result, 16'd142);
    chk16("div_rem", bus.result_hi, 16'd6);
    chk1 ("div_div0", bus.div0, 1'b0);
    issue(4'd9, 16'd5, 16'd0);
    wait_done(1, lat);
    chk_int("div0_lat", lat, 1);
    chk16("div0_res", bus.result, 16'hFFFF);
    chk16("div0_hi", bus.result_hi, 16'd5);
    chk1 ("div0_flag", bus.div0, 1'b1);
`else
    issue(4'd9, 16'd5, 16'd0);
    wait_done(1, lat);
    chk_int("op9_lat", lat, 1);
    chk16("op9_as_add", bus.result, 16'd5);
    chk1 ("op9_div0", bus.div0, 1'b0);
`endif
    tick();

    // Back-to-back: XOR issued in the MUL done cycle
    issue(4'd8, 16'h0003, 16'h0005);
    wait_done(1, lat);
    chk16("b2b_mul_res", bus.result, 16'h000F);
    issue(4'd7, 16'h00FF, 16'h0F0F);
    chk1 ("b2b_done", bus.done, 1'b1);
    chk16("b2b_xor_res", bus.result, 16'h0FF0);
    tick();

    // Reset during a MUL
    issue(4'd8, 16'h1234, 16'h0100);
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    chk_int("midreset_no_done", pulses, 0);
    issue(4'd0, 16'd2, 16'd3);
    wait_done(1, lat);
    chk_int("post_reset_lat", lat, 1);
    chk16("post_reset_add", bus.result, 16'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
